// File: rtl/uart_tx_feeder.sv
// Host-side character FIFO that feeds a UART transmitter one character at a time,
// holding txd_startH for START_CYC cycles and waiting for a txd_done rising edge.
module uart_tx_feeder #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8,
  parameter int START_CYC = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                 bclk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          count,
  output logic                 overflow,
  output logic [DATA_BITS-1:0] tx_data,
  output logic                 txd_startH,
  input  logic                 txd_done,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_BITS-1:0] tx_q, tx_d;
  logic                 done_q;
  logic                 done_rise, pop, push;
  logic [DATA_BITS-1:0] mem [DEPTH];

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign overflow   = ovf_q;
  assign tx_data    = tx_q;
  assign txd_startH = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign done_rise  = txd_done & ~done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        tx_d    = mem[rd_ptr_q];
        cnt_d   = 4'(START_CYC);
        state_d = START;
      end
      START: if (cnt_q == 4'd1) state_d = WAIT;
             else               cnt_d   = cnt_q - 4'd1;
      WAIT:  if (done_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A full FIFO still accepts a write when the head leaves on the same edge.
    push     = wr_en & (~full | pop);
    ovf_d    = ovf_q | (wr_en & ~push);
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      tx_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
      done_q   <= txd_done;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge bclk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized and directed bench for uart_tx_feeder against a queue-based model.
module tb_uart_tx_feeder;
  localparam int DB = 8, DEPTH = 8, SC = 2;

  logic       bclk = 0, rst = 1, wr_en = 0, txd_done = 0;
  logic [7:0] wr_data = 0;
  logic       full, empty, overflow, txd_startH, busy;
  logic [3:0] count;
  logic [7:0] tx_data;

  uart_tx_feeder #(.DATA_BITS(DB), .DEPTH(DEPTH), .START_CYC(SC)) dut (
    .bclk(bclk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .tx_data(tx_data),
    .txd_startH(txd_startH), .txd_done(txd_done), .busy(busy));

  always #5 bclk = ~bclk;

  int n_chk = 0, n_pass = 0;

  // Model: pending characters as a queue, the in-flight character as an age in cycles.
  logic [7:0] mq[$];
  logic [7:0] emitted[$];
  logic [7:0] m_tx = 0;
  bit m_inflight = 0, m_ovf = 0, m_prev_done = 0;
  int m_age = 0;

  always @(posedge bclk or posedge rst) begin
    if (rst) begin
      mq.delete(); m_tx = 0; m_inflight = 0; m_ovf = 0; m_prev_done = 0; m_age = 0;
    end else begin
      bit rise, do_pop, was_full, accept;
      rise        = txd_done && !m_prev_done;
      m_prev_done = txd_done;
      was_full    = (mq.size() == DEPTH);
      do_pop      = !m_inflight && mq.size() > 0;
      accept      = wr_en && (!was_full || do_pop);
      if (wr_en && !accept) m_ovf = 1;
      if (m_inflight) begin
        if (m_age >= SC && rise) m_inflight = 0;
        else if (m_age < SC)     m_age++;
      end else if (do_pop) begin
        m_tx = mq.pop_front();
        emitted.push_back(m_tx);
        m_inflight = 1;
        m_age = 0;
      end
      if (accept) mq.push_back(wr_data);
    end
  end

  always @(negedge bclk) begin
    bit exp_st, ok;
    exp_st = m_inflight && (m_age < SC);
    ok = (count == 4'(mq.size())) && (full == (mq.size() == DEPTH)) &&
         (empty == (mq.size() == 0)) && (overflow == m_ovf) &&
         (busy == m_inflight) && (txd_startH == exp_st) && (tx_data == m_tx);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL model t=%0t count=%0d/%0d full=%b empty=%b ovf=%b/%b busy=%b/%b startH=%b/%b tx=%h/%h",
                  $time, count, mq.size(), full, empty, overflow, m_ovf, busy, m_inflight,
                  txd_startH, exp_st, tx_data, m_tx);
  end

  task automatic tick();
    @(posedge bclk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask

  task automatic do_reset();
    rst = 1; wr_en = 0; txd_done = 0; tick(); tick(); rst = 0; tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick(); rst = 0; tick();
    chk("reset_count", count, 0); chk("reset_empty", empty, 1); chk("reset_full", full, 0);
    chk("reset_busy", busy, 0); chk("reset_ovf", overflow, 0); chk("reset_tx", tx_data, 0);

    // single character
    wr_en = 1; wr_data = 8'hA5; tick(); wr_en = 0;
    chk("single_cnt1", count, 1); chk("single_idle", busy, 0);
    tick(); chk("single_tx", tx_data, 8'hA5); chk("single_st1", txd_startH, 1);
    tick(); chk("single_st2", txd_startH, 1);
    tick(); chk("single_st_off", txd_startH, 0); chk("single_wait", busy, 1);
    txd_done = 1; tick(); chk("single_done", busy, 0); txd_done = 0; tick();

    // burst, simultaneous full write+pop, overflow, in-order drain
    do_reset(); emitted.delete();
    wr_en = 1; wr_data = 8'h55; tick(); wr_en = 0; tick(); tick(); tick();
    for (int k = 1; k <= 8; k++) begin wr_en = 1; wr_data = 8'(k); tick(); end
    wr_en = 0;
    chk("burst_full", full, 1); chk("burst_cnt", count, 8); chk("burst_ovf", overflow, 0);
    txd_done = 1; tick(); txd_done = 0;
    wr_en = 1; wr_data = 8'h09; tick(); wr_en = 0;
    chk("simul_cnt", count, 8); chk("simul_ovf", overflow, 0); chk("simul_tx", tx_data, 8'h01);
    tick(); tick();
    wr_en = 1; wr_data = 8'hFF; tick(); wr_en = 0;
    chk("ovf_set", overflow, 1); chk("ovf_cnt", count, 8);
    for (int k = 2; k <= 9; k++) begin
      txd_done = 1; tick(); txd_done = 0; tick();
      chk($sformatf("drain_%0d", k), tx_data, 32'(k));
      tick(); tick();
    end
    txd_done = 1; tick(); txd_done = 0; tick();
    chk("drain_empty", empty, 1); chk("drain_idle", busy, 0); chk("ovf_sticky", overflow, 1);
    chk("emit_n", emitted.size(), 10);
    if (emitted.size() == 10) begin
      chk("emit_0", emitted[0], 8'h55);
      for (int k = 1; k < 10; k++) chk($sformatf("emit_%0d", k), emitted[k], 32'(k));
    end

    // stuck-high txd_done, then reset mid-WAIT with three queued
    do_reset(); txd_done = 1;
    wr_en = 1; wr_data = 8'h3C; tick(); wr_en = 0;
    repeat (20) tick();
    chk("stuck_busy", busy, 1); chk("stuck_st", txd_startH, 0); chk("stuck_tx", tx_data, 8'h3C);
    for (int k = 0; k < 3; k++) begin wr_en = 1; wr_data = 8'(8'h77 + k); tick(); end
    wr_en = 0;
    chk("mid_cnt3", count, 3); chk("mid_busy", busy, 1);
    rst = 1; #1;
    chk("rst_busy", busy, 0); chk("rst_st", txd_startH, 0);
    chk("rst_cnt", count, 0); chk("rst_empty", empty, 1);
    tick(); rst = 0; txd_done = 0;
    repeat (10) tick();
    chk("post_rst_idle", busy, 0); chk("post_rst_tx", tx_data, 0);
    wr_en = 1; wr_data = 8'h42; tick(); wr_en = 0; tick();
    chk("post_rst_tx2", tx_data, 8'h42); chk("post_rst_st", txd_startH, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 9) < 4);
      wr_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) txd_done = ~txd_done;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; wr_en = 0; tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
